// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit common-anode 7-segment
// display. Each digit slot is a blanking interval (all anodes off) followed by
// an ON interval in which only that digit's anode is driven low. The digit
// code for the slot is presented on digit_out for the whole slot.
//
// New digit frames are double-buffered: a load strobe captures digits_flat into
// a shadow buffer. The shadow is copied into the active buffer only at a frame
// boundary, so a frame is never shown half old and half new.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank leading zeros. Digit 0 is always shown.
//
// Parameters:
//   NUM_DIGITS   - number of digits / anodes (2..8)
//   ON_CYCLES    - clk cycles an anode is lit per slot (>= 1)
//   BLANK_CYCLES - clk cycles of blanking before each digit (0 = none)
//
// Ports:
//   clk         - system clock
//   reset_n     - asynchronous active-low reset
//   en          - scan enable; 0 forces the display dark and the FSM to IDLE
//   load        - one-cycle strobe capturing digits_flat
//   digits_flat - digit codes, digit i at [4i+3:4i], digit 0 rightmost
//   digit_out   - registered code for the BCD-to-cathode decoder
//   anode       - registered active-low anode enables
//   frame_done  - one-cycle pulse after the last digit's ON period
//   pending     - shadow buffer holds a frame not yet applied
//   state_dbg   - current FSM state (0 IDLE, 1 BLANK, 2 ON)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_flat,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done,
    output logic                    pending,
    output logic [1:0]              state_dbg
);

    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    // Only used when BLANK_CYCLES > 0; the BLANK state is unreachable otherwise.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [4*NUM_DIGITS-1:0] active, active_nx;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
    logic                    pending_nx;
    logic [3:0]              digit_nx;
    logic [NUM_DIGITS-1:0]   anode_nx;
    logic                    frame_done_nx;
    logic                    enter_slot;
    logic                    frame_end;

    assign state_dbg = state;

    // Code shown for slot i of frame v.
    function automatic logic [3:0] slot_code(input logic [4*NUM_DIGITS-1:0] v,
                                             input logic [IDX_W-1:0]        i);
        logic [3:0] code;
`ifdef LEADING_ZERO_BLANK_EN
        logic       zero_above;
`endif
        code = v[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k > int'(i) && v[4*k +: 4] != 4'h0) zero_above = 1'b0;
        end
        if (i != '0 && code == 4'h0 && zero_above) code = 4'hF;
`endif
        return code;
    endfunction

    // Active-low one-hot anode pattern for slot i.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] i);
        return ~(NUM_DIGITS'(1) << i);
    endfunction

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        cnt_nx        = cnt + 1'b1;
        active_nx     = active;
        shadow_nx     = shadow;
        pending_nx    = pending;
        digit_nx      = digit_out;
        anode_nx      = anode;
        frame_done_nx = 1'b0;
        enter_slot    = 1'b0;

        // Last cycle of the last digit's ON period.
        frame_end = en && (state == ON) && (idx == LAST_IDX) && (cnt == ON_LAST);

        // Buffering. A load in IDLE or on the boundary cycle goes straight to
        // the active frame; otherwise it waits in the shadow. A later load
        // simply overwrites the shadow.
        if (load) begin
            shadow_nx = digits_flat;
            if (state == IDLE || frame_end) begin
                active_nx  = digits_flat;
                pending_nx = 1'b0;
            end else begin
                pending_nx = 1'b1;
            end
        end else if (frame_end && pending) begin
            active_nx  = shadow;
            pending_nx = 1'b0;
        end

        if (!en) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
            anode_nx = '1;
            digit_nx = 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    idx_nx     = '0;
                    enter_slot = 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = ON;
                        cnt_nx   = '0;
                        anode_nx = anode_for(idx);
                        digit_nx = slot_code(active_nx, idx);
                    end
                end
                ON: begin
                    if (cnt == ON_LAST) begin
                        enter_slot = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_nx        = '0;
                            frame_done_nx = 1'b1;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    anode_nx = '1;
                    digit_nx = 4'hF;
                end
            endcase
        end

        // Start of a new slot. digit_out reads active_nx so a frame swapped
        // in on this same edge is already visible for digit 0.
        if (enter_slot) begin
            cnt_nx   = '0;
            digit_nx = slot_code(active_nx, idx_nx);
            if (BLANK_CYCLES == 0) begin
                state_nx = ON;
                anode_nx = anode_for(idx_nx);
            end else begin
                state_nx = BLANK;
                anode_nx = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            active     <= '1;
            shadow     <= '1;
            pending    <= 1'b0;
            digit_out  <= 4'hF;
            anode      <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            active     <= active_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
            digit_out  <= digit_nx;
            anode      <= anode_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for seg_scan_ctrl with NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=1.
// Expected slot contents ({idx, code}) are queued when a frame is loaded; a
// negedge monitor pops one entry at the start of every ON slot and compares.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int ONC = 4;
    localparam int BLC = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_flat = 16'h0000;
    logic [3:0]  digit_out;
    logic [3:0]  anode;
    logic        frame_done;
    logic        pending;
    logic [1:0]  state_dbg;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b0;
    logic [3:0]  prev_anode = 4'hF;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .ON_CYCLES   (ONC),
        .BLANK_CYCLES(BLC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .load       (load),
        .digits_flat(digits_flat),
        .digit_out  (digit_out),
        .anode      (anode),
        .frame_done (frame_done),
        .pending    (pending),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        logic [3:0] exp_an;
        if (mon_en && reset_n && anode != prev_anode && anode != 4'hF) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL slot_unexpected: anode=%b digit=%h, no slot expected", anode, digit_out);
            end else begin
                e = exp_q.pop_front();
                exp_an = ~(4'b0001 << e[7:4]);
                if (anode !== exp_an || digit_out !== e[3:0]) begin
                    n_bad++;
                    $display("FAIL slot_content: anode=%b digit=%h, expected anode=%b digit=%h",
                             anode, digit_out, exp_an, e[3:0]);
                end
            end
        end
        prev_anode = anode;
    end

    // ---------------- driver tasks ----------------
    task automatic push_slot(input int i, input logic [3:0] code);
        exp_q.push_back({4'(i), code});
    endtask

    task automatic push_frame(input logic [15:0] f);
        for (int i = 0; i < N; i++) exp_q.push_back({4'(i), f[4*i +: 4]});
    endtask

    task automatic do_load(input logic [15:0] v);
        @(posedge clk); #1;
        load = 1'b1;
        digits_flat = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic start_scan();
        @(posedge clk); #1;
        en = 1'b1;
    endtask

    task automatic stop_scan();
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (anode !== 4'hF) begin n_bad++; $display("FAIL reset_anode: got %b want 1111", anode); end
        n_cmp++; if (digit_out !== 4'hF) begin n_bad++; $display("FAIL reset_digit: got %h want f", digit_out); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", pending); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (anode !== 4'hF) begin n_bad++; $display("FAIL idle_anode: got %b want 1111", anode); end
    endtask

    task automatic test_scan_timing();
        logic [3:0] exp_an;
        logic       exp_fd;
        start_scan();
        @(posedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < N; s++) begin
                for (int k = 0; k < BLC + ONC; k++) begin
                    @(negedge clk);
                    exp_an = (k < BLC) ? 4'hF : ~(4'b0001 << s);
                    exp_fd = (f == 1 && s == 0 && k == 0);
                    n_cmp++;
                    if (anode !== exp_an) begin
                        n_bad++;
                        $display("FAIL timing_anode f%0d s%0d k%0d: got %b want %b", f, s, k, anode, exp_an);
                    end
                    n_cmp++;
                    if (frame_done !== exp_fd) begin
                        n_bad++;
                        $display("FAIL timing_frame_done f%0d s%0d k%0d: got %b want %b", f, s, k, frame_done, exp_fd);
                    end
                end
            end
        end
        @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL timing_frame_done_2: got %b want 1", frame_done); end
        stop_scan();
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL timing_stop_state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_idle_load();
        bit ok;
        do_load(16'h1234);
        @(negedge clk);
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL idle_load_pending: got %b want 0", pending); end
        mon_en = 1'b1;
        push_frame(16'h1234);
        start_scan();
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL idle_load_drain: %0d slots left, want 0", exp_q.size()); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL idle_load_pending_end: got %b want 0", pending); end
        stop_scan();
    endtask

    task automatic test_midframe_load();
        bit ok;
        bit seen;
        push_frame(16'h1234);
        push_frame(16'h5678);
        start_scan();
        repeat (8) @(posedge clk);
        #1;
        load = 1'b1;
        digits_flat = 16'h5678;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL mid_load_pending: got %b want 1", pending); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_load_frame_done: got none want pulse"); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL mid_load_pending_clear: got %b want 0", pending); end
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_load_drain: %0d slots left, want 0", exp_q.size()); end
        stop_scan();
    endtask

    task automatic test_boundary_load();
        bit ok;
        push_frame(16'h5678);
        push_frame(16'h9999);
        start_scan();
        // Drive load during the last ON cycle of digit 3 (cycle 20 of the frame).
        repeat (20) @(posedge clk);
        #1;
        load = 1'b1;
        digits_flat = 16'h9999;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL boundary_frame_done: got %b want 1", frame_done); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL boundary_pending: got %b want 0", pending); end
        n_cmp++; if (digit_out !== 4'h9) begin n_bad++; $display("FAIL boundary_digit0: got %h want 9", digit_out); end
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL boundary_drain: %0d slots left, want 0", exp_q.size()); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL boundary_pending_end: got %b want 0", pending); end
        stop_scan();
    endtask

    task automatic test_back_to_back();
        bit ok;
        push_frame(16'h9999);
        push_frame(16'h0B0B);
        start_scan();
        repeat (5) @(posedge clk);
        #1;
        load = 1'b1;
        digits_flat = 16'hAAAA;
        @(posedge clk); #1;
        digits_flat = 16'h0B0B;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL b2b_pending: got %b want 1", pending); end
        wait_drain(60, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_drain: %0d slots left, want 0", exp_q.size()); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL b2b_pending_end: got %b want 0", pending); end
        stop_scan();
    endtask

    task automatic test_en_drop();
        bit ok;
        push_slot(0, 4'hB);
        push_slot(1, 4'h0);
        push_slot(2, 4'hB);
        start_scan();
        repeat (8) @(posedge clk);
        #1;
        load = 1'b1;
        digits_flat = 16'h4321;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        n_cmp++; if (anode !== 4'b1011) begin n_bad++; $display("FAIL drop_before: got %b want 1011", anode); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (anode !== 4'hF) begin n_bad++; $display("FAIL drop_anode: got %b want 1111", anode); end
        n_cmp++; if (digit_out !== 4'hF) begin n_bad++; $display("FAIL drop_digit: got %h want f", digit_out); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL drop_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL drop_state: got %0d want 0", state_dbg); end
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL drop_pending_kept: got %b want 1", pending); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL drop_slots_shown: %0d left, want 0", exp_q.size()); end
        push_frame(16'h0B0B);
        start_scan();
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (digit_out !== 4'hB || anode !== 4'hF) begin
            n_bad++; $display("FAIL restart_blank0: got anode %b digit %h want 1111 b", anode, digit_out);
        end
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL restart_drain: %0d slots left, want 0", exp_q.size()); end
        stop_scan();
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL restart_pending: got %b want 1", pending); end
    endtask

    task automatic test_leading_zero();
        bit ok;
        do_load(16'h0070);
        @(negedge clk);
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL lz_idle_pending: got %b want 0", pending); end
`ifdef LEADING_ZERO_BLANK_EN
        push_slot(0, 4'h0); push_slot(1, 4'h7); push_slot(2, 4'hF); push_slot(3, 4'hF);
`else
        push_slot(0, 4'h0); push_slot(1, 4'h7); push_slot(2, 4'h0); push_slot(3, 4'h0);
`endif
        start_scan();
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lz_0070_drain: %0d slots left, want 0", exp_q.size()); end
        stop_scan();
        do_load(16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
        push_slot(0, 4'h0); push_slot(1, 4'hF); push_slot(2, 4'hF); push_slot(3, 4'hF);
`else
        push_frame(16'h0000);
`endif
        start_scan();
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lz_0000_drain: %0d slots left, want 0", exp_q.size()); end
        stop_scan();
    endtask

    task automatic test_reset_async();
        bit ok;
        mon_en = 1'b0;
        exp_q.delete();
        start_scan();
        repeat (6) @(posedge clk);
        #1;
        load = 1'b1;
        digits_flat = 16'h1111;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        n_cmp++; if (pending !== 1'b1 || anode === 4'hF) begin
            n_bad++; $display("FAIL async_pre: got pending %b anode %b want 1 and lit", pending, anode);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (anode !== 4'hF) begin n_bad++; $display("FAIL async_anode: got %b want 1111", anode); end
        n_cmp++; if (digit_out !== 4'hF) begin n_bad++; $display("FAIL async_digit: got %h want f", digit_out); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL async_pending: got %b want 0", pending); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL async_state: got %0d want 0", state_dbg); end
        en = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        // Buffers must have returned to all-blank codes.
        mon_en = 1'b1;
        push_frame(16'hFFFF);
        start_scan();
        wait_drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL async_after_drain: %0d slots left, want 0", exp_q.size()); end
        stop_scan();
        mon_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_idle_load();
        test_midframe_load();
        test_boundary_load();
        test_back_to_back();
        test_en_drop();
        test_leading_zero();
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
